// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_stall_controller
//  Purpose  : Central stall/flush sequencer for the 5-stage MIPS pipeline.
//             Merges the hazard detector's request, the EXE-stage branch-taken
//             signal and the data-memory wait into one prioritised set of
//             freeze/flush/bubble controls (mem_busy > br_taken > hazard_det).
//  Ports    : clk, rst (sync, active-high)
//             hazard_det, br_taken, mem_busy          - requests
//             pc_freeze, if_id_freeze, if_id_flush,
//             id_exe_bubble, pipe_hold                - pipeline controls
//             stall_err                                - sticky runaway-stall flag
//             state_o[1:0]                             - 0 RUN 1 HAZ 2 MEMW 3 FLUSH
//             (STALL_PERF_CNT_EN) perf_clr, stall_cycles[31:0], flush_count[15:0]
//  Options  : define STALL_PERF_CNT_EN to add the performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller #(
   parameter int FLUSH_CYCLES = 2,   // 1..7
   parameter int MAX_STALL    = 16   // 2..255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hazard_det,
   input  logic        br_taken,
   input  logic        mem_busy,
`ifdef STALL_PERF_CNT_EN
   input  logic        perf_clr,
   output logic [31:0] stall_cycles,
   output logic [15:0] flush_count,
`endif
   output logic        pc_freeze,
   output logic        if_id_freeze,
   output logic        if_id_flush,
   output logic        id_exe_bubble,
   output logic        pipe_hold,
   output logic        stall_err,
   output logic [1:0]  state_o
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HAZ   = 2'd1,
      ST_MEMW  = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [7:0] STALL_LIMIT  = 8'(MAX_STALL - 1);

   state_t     state_q, state_d;
   logic [2:0] flush_cnt_q, flush_cnt_d;
   logic [7:0] run_cnt_q, run_cnt_d;
   logic       stall_err_q, stall_err_d;

   logic       ctl_pc_freeze, ctl_if_id_freeze, ctl_if_id_flush;
   logic       ctl_id_exe_bubble, ctl_pipe_hold;
   logic       br_accept;

   always_comb begin
      ctl_pc_freeze     = 1'b0;
      ctl_if_id_freeze  = 1'b0;
      ctl_if_id_flush   = 1'b0;
      ctl_id_exe_bubble = 1'b0;
      ctl_pipe_hold     = 1'b0;
      br_accept         = 1'b0;
      state_d           = state_q;
      flush_cnt_d       = flush_cnt_q;
      // Only back-to-back hazard cycles count; every other cycle restarts the run.
      run_cnt_d         = 8'd0;
      stall_err_d       = stall_err_q;

      if (mem_busy) begin
         // Whole pipe holds; EXE is frozen so its branch/hazard will be
         // re-presented once memory is ready. A pending flush is paused.
         ctl_pc_freeze    = 1'b1;
         ctl_if_id_freeze = 1'b1;
         ctl_pipe_hold    = 1'b1;
         if (state_q != ST_FLUSH) begin
            state_d = ST_MEMW;
         end
      end else if (state_q == ST_FLUSH) begin
         // The instruction in EXE is a bubble: it cannot branch or stall.
         ctl_if_id_flush   = 1'b1;
         ctl_id_exe_bubble = 1'b1;
         flush_cnt_d       = flush_cnt_q - 3'd1;
         if (flush_cnt_q == 3'd1) begin
            state_d = ST_RUN;
         end
      end else if (br_taken) begin
         // PC loads the target, so it is not frozen.
         ctl_if_id_flush   = 1'b1;
         ctl_id_exe_bubble = 1'b1;
         br_accept         = 1'b1;
         if (FLUSH_CYCLES == 1) begin
            state_d = ST_RUN;
         end else begin
            flush_cnt_d = FLUSH_RELOAD;
            state_d     = ST_FLUSH;
         end
      end else if (hazard_det) begin
         ctl_pc_freeze     = 1'b1;
         ctl_if_id_freeze  = 1'b1;
         ctl_id_exe_bubble = 1'b1;
         state_d           = ST_HAZ;
         run_cnt_d         = (run_cnt_q == 8'hFF) ? run_cnt_q : run_cnt_q + 8'd1;
         // This cycle is stall number run_cnt_q+1; reaching MAX_STALL flags it.
         if (run_cnt_q >= STALL_LIMIT) begin
            stall_err_d = 1'b1;
         end
      end else begin
         state_d = ST_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         flush_cnt_q <= 3'd0;
         run_cnt_q   <= 8'd0;
         stall_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         run_cnt_q   <= run_cnt_d;
         stall_err_q <= stall_err_d;
      end
   end

   // Reset overrides every output combinationally, including the first cycle
   // when the registers have not yet been initialised.
   assign pc_freeze     = ctl_pc_freeze     & ~rst;
   assign if_id_freeze  = ctl_if_id_freeze  & ~rst;
   assign if_id_flush   = ctl_if_id_flush   & ~rst;
   assign id_exe_bubble = ctl_id_exe_bubble & ~rst;
   assign pipe_hold     = ctl_pipe_hold     & ~rst;
   assign stall_err     = stall_err_q       & ~rst;
   assign state_o       = rst ? 2'd0 : state_q;

`ifdef STALL_PERF_CNT_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [15:0] flush_count_q, flush_count_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (perf_clr) begin
         stall_cycles_d = 32'd0;
         flush_count_d  = 16'd0;
      end else begin
         if (pc_freeze) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
         end
         if (br_accept) begin
            flush_count_d = flush_count_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= 32'd0;
         flush_count_q  <= 16'd0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_stall_controller
//  Purpose  : Self-checking bench for pipeline_stall_controller (default build):
//             directed vector table, hand-written multi-cycle sequences and a
//             randomised run against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_controller;

   localparam int FLUSH_CYCLES = 2;
   localparam int MAX_STALL    = 16;

   logic       clk;
   logic       rst, hazard_det, br_taken, mem_busy;
   logic       pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, pipe_hold, stall_err;
   logic [1:0] state_o;
   logic [7:0] obs;

   int checks = 0;
   int errors = 0;

   pipeline_stall_controller #(
      .FLUSH_CYCLES (FLUSH_CYCLES),
      .MAX_STALL    (MAX_STALL)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .hazard_det    (hazard_det),
      .br_taken      (br_taken),
      .mem_busy      (mem_busy),
      .pc_freeze     (pc_freeze),
      .if_id_freeze  (if_id_freeze),
      .if_id_flush   (if_id_flush),
      .id_exe_bubble (id_exe_bubble),
      .pipe_hold     (pipe_hold),
      .stall_err     (stall_err),
      .state_o       (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, pipe_hold, state_o, stall_err}
   assign obs = {pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, pipe_hold, state_o, stall_err};

   localparam logic [4:0] C_IDLE  = 5'b00000;
   localparam logic [4:0] C_HAZ   = 5'b11010;
   localparam logic [4:0] C_FLUSH = 5'b00110;
   localparam logic [4:0] C_HOLD  = 5'b11001;

   typedef struct {
      logic       r, m, b, h;
      logic [4:0] ctl;
      logic [1:0] st;
      logic       err;
   } vec_t;

   vec_t tbl [$];

   task automatic add(input logic r, m, b, h, input logic [4:0] c, input logic [1:0] s, input logic e);
      vec_t v;
      v.r = r; v.m = m; v.b = b; v.h = h; v.ctl = c; v.st = s; v.err = e;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got ctl/st/err=%b required %b", nm, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs just after a rising edge, compare on the
   // falling edge, then advance past the next rising edge.
   task automatic step(input logic r, m, b, h, input logic [4:0] c, input logic [1:0] s,
                       input logic e, input string nm);
      rst = r; mem_busy = m; br_taken = b; hazard_det = h;
      @(negedge clk);
      chk(nm, {c, s, e});
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural reference model ----------------
   // Tracks: flush cycles still owed, length of the current hazard run,
   // what the previous cycle was (0 other, 1 hazard stall, 2 memory wait).
   int mdl_flush_left, mdl_run, mdl_prev;
   bit mdl_err;

   task automatic model(input logic r, m, b, h, output logic [7:0] exp);
      logic [4:0] c;
      logic [1:0] s;
      if (r) begin
         exp = 8'd0;
         mdl_flush_left = 0; mdl_run = 0; mdl_prev = 0; mdl_err = 1'b0;
         return;
      end
      if (mdl_flush_left > 0)  s = 2'd3;
      else if (mdl_prev == 2)  s = 2'd2;
      else if (mdl_prev == 1)  s = 2'd1;
      else                     s = 2'd0;
      exp = {5'b0, s, mdl_err};
      c = C_IDLE;
      if (m) begin
         c = C_HOLD; mdl_prev = 2; mdl_run = 0;
      end else if (mdl_flush_left > 0) begin
         c = C_FLUSH; mdl_flush_left--; mdl_prev = 0; mdl_run = 0;
      end else if (b) begin
         c = C_FLUSH; mdl_flush_left = FLUSH_CYCLES - 1; mdl_prev = 0; mdl_run = 0;
      end else if (h) begin
         c = C_HAZ; mdl_prev = 1; mdl_run++;
         if (mdl_run >= MAX_STALL) mdl_err = 1'b1;
      end else begin
         mdl_prev = 0; mdl_run = 0;
      end
      exp[7:3] = c;
   endtask

   initial begin
      logic [7:0] exp;
      rst = 1'b1; mem_busy = 1'b0; br_taken = 1'b0; hazard_det = 1'b0;

      // ---- directed vector table ----
      // reset then idle
      add(1,0,0,0, C_IDLE, 2'd0, 0);
      add(1,0,0,0, C_IDLE, 2'd0, 0);
      add(1,0,0,0, C_IDLE, 2'd0, 0);
      add(0,0,0,0, C_IDLE, 2'd0, 0);
      // single hazard cycle
      add(0,0,0,1, C_HAZ,  2'd0, 0);
      add(0,0,0,0, C_IDLE, 2'd1, 0);
      add(0,0,0,0, C_IDLE, 2'd0, 0);
      // branch taken: two flush cycles, hazard ignored in the second
      add(0,0,1,0, C_FLUSH, 2'd0, 0);
      add(0,0,0,1, C_FLUSH, 2'd3, 0);
      add(0,0,0,0, C_IDLE,  2'd0, 0);
      // memory wait masks branch and hazard; branch taken when it drops
      add(0,1,1,1, C_HOLD,  2'd0, 0);
      add(0,1,1,1, C_HOLD,  2'd2, 0);
      add(0,1,1,1, C_HOLD,  2'd2, 0);
      add(0,1,1,1, C_HOLD,  2'd2, 0);
      add(0,0,1,1, C_FLUSH, 2'd2, 0);
      add(0,0,0,0, C_FLUSH, 2'd3, 0);
      add(0,0,0,0, C_IDLE,  2'd0, 0);
      // memory wait out of a hazard goes to MEMW, then hazard re-presented
      add(0,0,0,1, C_HAZ,  2'd0, 0);
      add(0,1,0,1, C_HOLD, 2'd1, 0);
      add(0,0,0,1, C_HAZ,  2'd2, 0);
      add(0,0,0,0, C_IDLE, 2'd1, 0);
      add(0,0,0,0, C_IDLE, 2'd0, 0);

      @(posedge clk);
      #1;
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].r, tbl[i].m, tbl[i].b, tbl[i].h, tbl[i].ctl, tbl[i].st, tbl[i].err,
              $sformatf("vec%0d", i));
      end

      // ---- memory wait inside the second flush cycle ----
      step(0,0,1,0, C_FLUSH, 2'd0, 0, "fl_mem_start");
      for (int i = 0; i < 3; i++) step(0,1,0,0, C_HOLD, 2'd3, 0, $sformatf("fl_mem_hold%0d", i));
      step(0,0,0,0, C_FLUSH, 2'd3, 0, "fl_mem_resume");
      step(0,0,0,0, C_IDLE,  2'd0, 0, "fl_mem_done");

      // ---- stall_err threshold ----
      step(1,0,0,0, C_IDLE, 2'd0, 0, "err_rst_a");
      for (int i = 0; i < MAX_STALL - 1; i++)
         step(0,0,0,1, C_HAZ, (i == 0) ? 2'd0 : 2'd1, 0, $sformatf("haz15_%0d", i));
      step(0,0,0,0, C_IDLE, 2'd1, 0, "haz15_noerr");
      step(0,0,0,0, C_IDLE, 2'd0, 0, "haz15_idle");
      for (int i = 0; i < MAX_STALL; i++)
         step(0,0,0,1, C_HAZ, (i == 0) ? 2'd0 : 2'd1, 0, $sformatf("haz16_%0d", i));
      step(0,0,0,0, C_IDLE,  2'd1, 1, "haz16_err");
      step(0,0,0,0, C_IDLE,  2'd0, 1, "err_sticky_idle");
      step(0,0,1,0, C_FLUSH, 2'd0, 1, "err_sticky_br");
      step(0,0,0,0, C_FLUSH, 2'd3, 1, "err_sticky_fl");
      step(1,0,0,0, C_IDLE,  2'd0, 0, "err_rst_b");
      step(0,0,0,0, C_IDLE,  2'd0, 0, "err_cleared");

      // ---- randomised run against the model ----
      for (int i = 0; i < 4000; i++) begin
         logic r, m, b, h;
         bit   long_haz;
         long_haz = ((i / 200) % 2) == 1;
         r = (i == 0) || ($urandom_range(0, 699) == 0);
         if (long_haz) begin
            m = ($urandom_range(0, 39) == 0);
            b = ($urandom_range(0, 39) == 0);
            h = ($urandom_range(0, 19) != 0);
         end else begin
            m = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 5) == 0);
            h = ($urandom_range(0, 1) == 0);
         end
         model(r, m, b, h, exp);
         step(r, m, b, h, exp[7:3], exp[2:1], exp[0], $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
